// File: rtl/vedic_mul_wide_seq.sv
// Wide unsigned multiplier built from one shared 16x16 Vedic core.
// Word-pair partial products are issued one per cycle and shift-accumulated into the product.

module simple_vedic_16bit #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] s
);
    localparam int H  = W / 2;
    localparam int CW = $clog2(H + 1);

    logic [2*H-1:0] ll_q;
    logic [2*H-1:0] lh_q;
    logic [2*H-1:0] hl_q;
    logic [2*H-1:0] hh_q;
    logic [2*H:0]   mid;

    // Urdhva-Tiryagbhyam: vertical/crosswise column sums, then one carry-resolving add.
    function automatic logic [2*H-1:0] urdhva(input logic [H-1:0] u, input logic [H-1:0] v);
        logic [CW-1:0]  cols [2*H-1];
        logic [2*H-1:0] prod;
        for (int c = 0; c < 2*H-1; c++) begin
            cols[c] = '0;
        end
        for (int r = 0; r < H; r++) begin
            for (int q = 0; q < H; q++) begin
                cols[r+q] = cols[r+q] + CW'(u[r] & v[q]);
            end
        end
        prod = '0;
        for (int c = 0; c < 2*H-1; c++) begin
            prod = prod + ((2*H)'(cols[c]) << c);
        end
        return prod;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ll_q <= '0;
            lh_q <= '0;
            hl_q <= '0;
            hh_q <= '0;
        end else begin
            ll_q <= urdhva(x[H-1:0], y[H-1:0]);
            lh_q <= urdhva(x[H-1:0], y[W-1:H]);
            hl_q <= urdhva(x[W-1:H], y[H-1:0]);
            hh_q <= urdhva(x[W-1:H], y[W-1:H]);
        end
    end

    assign mid = {1'b0, lh_q} + {1'b0, hl_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else begin
            s <= {hh_q, ll_q} + ((2*W)'(mid) << H);
        end
    end
endmodule

module vedic_mul_wide_seq #(
    parameter int NW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NW*16-1:0]    a,
    input  logic [NW*16-1:0]    b,
    output logic                busy,
    output logic                done,
    output logic [2*NW*16-1:0]  p
);
    localparam int W  = 16;
    localparam int AW = NW * W;
    localparam int PW = 2 * AW;
    localparam int IW = $clog2(NW);
    localparam int SW = $clog2(2*NW - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   a_q;
    logic [AW-1:0]   b_q;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic [IW-1:0]   i_idx;
    logic [IW-1:0]   j_idx;
    logic            drain_cnt;
    logic            issue_last;
    logic            issue_valid;
    logic [W-1:0]    mul_x;
    logic [W-1:0]    mul_y;
    logic [2*W-1:0]  mul_s;
    logic            tag1_valid;
    logic [SW-1:0]   tag1_shift;
    logic            tag2_valid;
    logic [SW-1:0]   tag2_shift;

    simple_vedic_16bit #(.W(W)) u_mul (
        .clk (clk),
        .rst (rst),
        .x   (mul_x),
        .y   (mul_y),
        .s   (mul_s)
    );

    assign issue_last = (i_idx == IW'(NW-1)) && (j_idx == IW'(NW-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = ISSUE;
            ISSUE:   if (issue_last) state_next = DRAIN;
            DRAIN:   if (drain_cnt)  state_next = DONE;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        issue_valid = (state == ISSUE);
        mul_x       = '0;
        mul_y       = '0;
        if (state == ISSUE) begin
            mul_x = a_q[int'(i_idx)*W +: W];
            mul_y = b_q[int'(j_idx)*W +: W];
        end
    end

    // The tag riding alongside the multiplier pipeline says where its result lands.
    always_comb begin
        acc_next = acc;
        if (tag2_valid) begin
            acc_next = acc + (PW'(mul_s) << (W * int'(tag2_shift)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            p          <= '0;
            i_idx      <= '0;
            j_idx      <= '0;
            drain_cnt  <= 1'b0;
            tag1_valid <= 1'b0;
            tag1_shift <= '0;
            tag2_valid <= 1'b0;
            tag2_shift <= '0;
        end else begin
            tag1_valid <= issue_valid;
            tag1_shift <= issue_valid ? (SW'(i_idx) + SW'(j_idx)) : '0;
            tag2_valid <= tag1_valid;
            tag2_shift <= tag1_shift;
            drain_cnt  <= (state == DRAIN) ? drain_cnt + 1'b1 : 1'b0;

            if (state == IDLE && start) begin
                a_q   <= a;
                b_q   <= b;
                acc   <= '0;
                i_idx <= '0;
                j_idx <= '0;
            end else begin
                acc <= acc_next;
                if (state == ISSUE) begin
                    if (i_idx == IW'(NW-1)) begin
                        i_idx <= '0;
                        j_idx <= j_idx + IW'(1);
                    end else begin
                        i_idx <= i_idx + IW'(1);
                    end
                end
            end

            // The last in-flight product lands this cycle, so publish the sum including it.
            if (state == DRAIN && drain_cnt) begin
                p <= acc_next;
            end
        end
    end
endmodule

// File: tb/tb_vedic_mul_wide_seq.sv
// Scoreboard bench for vedic_mul_wide_seq (NW=4): stimulus pushes expected products,
// a monitor pops and compares on every done pulse.

module tb_vedic_mul_wide_seq;
    localparam int NW  = 4;
    localparam int LAT = NW*NW + 3;

    typedef struct {
        logic [127:0] p;
        int           cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [63:0]   a = '0;
    logic [63:0]   b = '0;
    logic          busy;
    logic          done;
    logic [127:0]  p;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   t6_mode = 1'b0;
    bit   last_done_valid = 1'b0;
    int   last_done = 0;
    int   acc_cyc;
    exp_t sbq[$];

    vedic_mul_wide_seq #(.NW(NW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done with empty scoreboard, required none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("product", p, e.p);
                checkOutput("done_cycle", 128'(cyc), 128'(e.cyc));
            end
            if (t6_mode && last_done_valid) begin
                checkOutput("done_spacing", 128'(cyc - last_done), 128'(20));
            end
            last_done       = cyc;
            last_done_valid = 1'b1;
        end
    end

    task automatic waitIdle();
        int n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            tests++;
            fails++;
            $display("[TB] FAIL idle_timeout: got busy=%0b done=%0b, required idle within 200 cycles", busy, done);
        end
    endtask

    // Returns in the cycle right after the accept cycle.
    task automatic applyStimulus(input logic [63:0] ta, input logic [63:0] tb_in, input logic [127:0] exp_p,
                                 input bit push, output int accepted);
        exp_t e;
        waitIdle();
        a        = ta;
        b        = tb_in;
        start    = 1'b1;
        accepted = cyc;
        if (push) begin
            e.p   = exp_p;
            e.cyc = cyc + LAT;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_done", 128'(done), 128'(0));
        checkOutput("reset_p", p, 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // T1: zero operand
        applyStimulus(64'h0, 64'h0123_4567_89AB_CDEF, 128'h0, 1'b1, acc_cyc);

        // T2: all ones, full carry chains
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                      128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b1, acc_cyc);

        // T3: identity, with exact busy/done windows
        applyStimulus(64'h1, 64'h1234_5678_9ABC_DEF0,
                      128'h0000_0000_0000_0000_1234_5678_9ABC_DEF0, 1'b1, acc_cyc);
        for (int k = 1; k <= LAT + 1; k++) begin
            checkOutput("t3_busy", 128'(busy), 128'(k <= LAT));
            checkOutput("t3_done", 128'(done), 128'(k == LAT));
            @(negedge clk);
        end

        // T4: starts during ISSUE and in the DONE cycle are ignored
        applyStimulus(64'h0000_0000_0001_0000, 64'h3, 128'h3_0000, 1'b1, acc_cyc);
        for (int k = 1; k <= LAT; k++) begin
            if (k == 5 || k == LAT) begin
                start = 1'b1;
                a     = 64'hFFFF_FFFF_FFFF_FFFF;
                b     = 64'hAAAA_5555_AAAA_5555;
            end else begin
                start = 1'b0;
            end
            if (k == 10) begin
                checkOutput("t4_p_hold", p, 128'h0000_0000_0000_0000_1234_5678_9ABC_DEF0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("t4_idle_after_done", 128'(busy), 128'(0));
        repeat (25) @(negedge clk);
        checkOutput("t4_p_kept", p, 128'h3_0000);

        // T5: reset in cycle 10 aborts, then a clean operation
        applyStimulus(64'hDEAD_BEEF_CAFE_F00D, 64'h0BAD_F00D_1234_5678, 128'h0, 1'b0, acc_cyc);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t5_busy", 128'(busy), 128'(0));
        checkOutput("t5_done", 128'(done), 128'(0));
        checkOutput("t5_p", p, 128'(0));
        applyStimulus(64'h0000_0000_0000_FFFF, 64'h0000_0000_0001_0001, 128'hFFFF_FFFF, 1'b1, acc_cyc);

        // T6: back-to-back random operands against a plain arithmetic reference
        waitIdle();
        t6_mode         = 1'b1;
        last_done_valid = 1'b0;
        for (int n = 0; n < 200; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            applyStimulus(ra, rb, {64'h0, ra} * {64'h0, rb}, 1'b1, acc_cyc);
        end
        waitIdle();
        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", 128'(sbq.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
